// File: rtl/pc_fetch_ctrl.sv
// PC/fetch sequencer for the instruction ROM: sequential advance, jumps, relative branches, stall/halt, fault.
// Latency: redirect decided in cycle n shows on prog_ctr after that edge; stall holds the PC with no other backpressure.
module pc_fetch_ctrl #(
    parameter int D          = 12,
    parameter int START_ADDR = 0,
    parameter int OFFW       = 6,
    parameter int CW         = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            halt,
    input  logic            stall,
    input  logic            abs_jump,
    input  logic [D-1:0]    target,
    input  logic            rel_branch,
    input  logic            branch_taken,
    input  logic [OFFW-1:0] offset,
    output logic [D-1:0]    prog_ctr,
    output logic            running,
    output logic            done,
    output logic            fault,
    output logic [CW-1:0]   cycle_cnt
);

    localparam logic [D-1:0]  START_PC = D'(START_ADDR);
    localparam logic [D-1:0]  PC_MAX   = '1;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_FAULT} state_t;

    state_t        state, state_nxt;
    logic [D-1:0]  pc_nxt;
    logic [CW-1:0] cnt_nxt;
    logic [D:0]    br_sum;

    // The true sum lies in (-2**D, 2**(D+1)), so bit D is set exactly when the target is out of range.
    assign br_sum = {1'b0, prog_ctr} + {{(D + 1 - OFFW){offset[OFFW-1]}}, offset};

    always_comb begin
        state_nxt = state;
        pc_nxt    = prog_ctr;
        cnt_nxt   = cycle_cnt;
        case (state)
            S_RUN: begin
                if (cycle_cnt != CNT_MAX) begin
                    cnt_nxt = cycle_cnt + CW'(1);
                end
                if (halt) begin
                    state_nxt = S_DONE;
                end else if (!stall) begin
                    if (abs_jump) begin
                        pc_nxt = target;
                    end else if (rel_branch && branch_taken) begin
                        if (br_sum[D]) begin
                            state_nxt = S_FAULT;
                        end else begin
                            pc_nxt = br_sum[D-1:0];
                        end
                    end else if (prog_ctr == PC_MAX) begin
                        state_nxt = S_FAULT;
                    end else begin
                        pc_nxt = prog_ctr + D'(1);
                    end
                end
            end
            default: begin
                if (start) begin
                    state_nxt = S_RUN;
                    pc_nxt    = START_PC;
                    cnt_nxt   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            prog_ctr  <= START_PC;
            cycle_cnt <= '0;
            running   <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_nxt;
            prog_ctr  <= pc_nxt;
            cycle_cnt <= cnt_nxt;
            running   <= (state_nxt == S_RUN);
            done      <= (state_nxt == S_DONE);
            fault     <= (state_nxt == S_FAULT);
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios then random traffic against a behavioural model.
// A second instance with a 4-bit counter exposes cycle_cnt saturation.
module tb_pc_fetch_ctrl;

    localparam int D = 12, OFFW = 6;
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_FAULT = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0, halt = 1'b0, stall = 1'b0, abs_jump = 1'b0;
    logic            rel_branch = 1'b0, branch_taken = 1'b0;
    logic [D-1:0]    target = '0;
    logic [OFFW-1:0] offset = '0;

    logic [D-1:0] prog_ctr, prog_ctr_s;
    logic         running, done, fault, running_s, done_s, fault_s;
    logic [15:0]  cycle_cnt;
    logic [3:0]   cycle_cnt_s;

    int n_cmp = 0, n_err = 0;
    int m_st = M_IDLE, m_pc = 0, m_cnt = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(.D(D), .START_ADDR(0), .OFFW(OFFW), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .stall(stall),
        .abs_jump(abs_jump), .target(target), .rel_branch(rel_branch),
        .branch_taken(branch_taken), .offset(offset), .prog_ctr(prog_ctr),
        .running(running), .done(done), .fault(fault), .cycle_cnt(cycle_cnt)
    );

    pc_fetch_ctrl #(.D(D), .START_ADDR(0), .OFFW(OFFW), .CW(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .stall(stall),
        .abs_jump(abs_jump), .target(target), .rel_branch(rel_branch),
        .branch_taken(branch_taken), .offset(offset), .prog_ctr(prog_ctr_s),
        .running(running_s), .done(done_s), .fault(fault_s), .cycle_cnt(cycle_cnt_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_flags();
        return {m_st == M_RUN, m_st == M_DONE, m_st == M_FAULT};
    endfunction

    task automatic check_all();
        check("pc", prog_ctr, m_pc);
        check("flags", {running, done, fault}, exp_flags());
        check("cnt", cycle_cnt, (m_cnt > 65535) ? 65535 : m_cnt);
        check("pc_s", prog_ctr_s, m_pc);
        check("flags_s", {running_s, done_s, fault_s}, exp_flags());
        check("cnt_s", cycle_cnt_s, (m_cnt > 15) ? 15 : m_cnt);
    endtask

    // Reference behaviour for one clock edge.
    task automatic model_edge();
        int t;
        if (!rst_n) begin
            m_st = M_IDLE; m_pc = 0; m_cnt = 0;
        end else if (m_st == M_RUN) begin
            m_cnt++;
            if (halt) m_st = M_DONE;
            else if (stall) m_st = M_RUN;
            else if (abs_jump) m_pc = int'(target);
            else if (rel_branch && branch_taken) begin
                t = m_pc + int'($signed(offset));
                if (t < 0 || t > 4095) m_st = M_FAULT;
                else m_pc = t;
            end else if (m_pc == 4095) m_st = M_FAULT;
            else m_pc++;
        end else if (start) begin
            m_st = M_RUN; m_pc = 0; m_cnt = 0;
        end
    endtask

    task automatic clr();
        start = 0; halt = 0; stall = 0; abs_jump = 0;
        rel_branch = 0; branch_taken = 0; target = '0; offset = '0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        clr();
    endtask

    task automatic pulse_start();
        start = 1; step();
    endtask

    task automatic jump_to(input int a);
        abs_jump = 1; target = D'(a); step();
    endtask

    task automatic async_reset();
        #2 rst_n = 0;
        #1;
        m_st = M_IDLE; m_pc = 0; m_cnt = 0;
        check_all();
    endtask

    initial begin
        clr();
        #2;
        m_st = M_IDLE; m_pc = 0; m_cnt = 0;
        check_all();
        step();
        #3 rst_n = 1;

        // Sequential advance
        pulse_start();
        for (int i = 0; i < 5; i++) step();
        check("tp_seq_pc", prog_ctr, 5);
        check("tp_seq_cnt", cycle_cnt, 5);
        check("tp_seq_run", running, 1);

        // Jump then relative branch back 3, and untaken branch
        for (int i = 0; i < 5; i++) step();
        check("tp_pc10", prog_ctr, 10);
        jump_to(12'h200);
        check("tp_jmp", prog_ctr, 12'h200);
        rel_branch = 1; branch_taken = 1; offset = 6'b111101; step();
        check("tp_rel", prog_ctr, 12'h1FD);
        jump_to(12'h200);
        rel_branch = 1; branch_taken = 0; offset = 6'b111101; step();
        check("tp_nt", prog_ctr, 12'h201);

        // Stall then halt, restart
        jump_to(20);
        for (int i = 0; i < 3; i++) begin stall = 1; step(); end
        halt = 1; step();
        check("tp_halt_pc", prog_ctr, 20);
        check("tp_halt_done", done, 1);
        step();
        check("tp_done_sticky", {done, prog_ctr}, {1'b1, 12'd20});
        pulse_start();
        check("tp_restart", {done, running, prog_ctr}, {2'b01, 12'd0});

        // Wrap fault, then negative branch fault
        jump_to(12'hFFF);
        step();
        check("tp_wrap", {fault, prog_ctr}, {1'b1, 12'hFFF});
        pulse_start();
        step(); step();
        rel_branch = 1; branch_taken = 1; offset = 6'(-5); step();
        check("tp_negbr", {fault, prog_ctr}, {1'b1, 12'd2});

        // Priority: stall over jumps, jump over branch, halt over stall
        pulse_start();
        step();
        abs_jump = 1; target = 12'h40; rel_branch = 1; branch_taken = 1; offset = 6'd7; stall = 1; step();
        check("tp_stall_prio", prog_ctr, 1);
        abs_jump = 1; target = 12'h40; rel_branch = 1; branch_taken = 1; offset = 6'd7; step();
        check("tp_abs_prio", prog_ctr, 12'h40);
        rel_branch = 1; branch_taken = 1; offset = 6'd0; step();
        check("tp_off0", {fault, prog_ctr}, {1'b0, 12'h40});
        halt = 1; stall = 1; step();
        check("tp_halt_prio", done, 1);

        // Asynchronous reset between edges
        pulse_start();
        jump_to(12'h33);
        async_reset();
        check("tp_arst", {running, prog_ctr}, {1'b0, 12'd0});
        step(); step();
        #2 rst_n = 1;
        step();
        check("tp_idle_hold", {running, prog_ctr}, {1'b0, 12'd0});

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
                step();
                #2 rst_n = 1;
            end
            start        = ($urandom_range(0, 7) == 0);
            halt         = ($urandom_range(0, 39) == 0);
            stall        = ($urandom_range(0, 3) == 0);
            abs_jump     = ($urandom_range(0, 7) == 0);
            rel_branch   = ($urandom_range(0, 3) == 0);
            branch_taken = $urandom_range(0, 1) == 1;
            offset       = OFFW'($urandom);
            target       = ($urandom_range(0, 2) == 0) ? D'(4095 - $urandom_range(0, 20)) : D'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter and fetch sequencer directly upstream of the 9-bit instruction ROM.
- Drives the ROM address `prog_ctr` every cycle. Advances sequentially, or redirects on absolute jumps and taken relative branches from control decode.
- Handles stall and halt, and a start/done handshake with the testbench/top level.
- Detects illegal PC wrap or out-of-range branch targets and stops in a fault state.

Parameters:
- D, 12, address width; must match the instruction ROM depth 2**D.
- START_ADDR, 0, PC value loaded on reset and on every accepted start.
- OFFW, 6, width of the signed relative-branch offset (two's complement).
- CW, 16, width of the run-cycle counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin execution at START_ADDR; sampled on the clock edge.
- halt  input  1  current instruction is HALT (from decode).
- stall  input  1  hold the PC this cycle.
- abs_jump  input  1  absolute jump request.
- target  input  D  absolute jump address.
- rel_branch  input  1  relative branch instruction present.
- branch_taken  input  1  branch condition true (from ALU flag).
- offset  input  OFFW  signed relative offset, applied to the current PC.
- prog_ctr  output  D  registered ROM address.
- running  output  1  high while in RUN.
- done  output  1  high while in DONE.
- fault  output  1  high while in FAULT.
- cycle_cnt  output  CW  cycles spent in RUN since the last accepted start.

Behaviour:

States: IDLE, RUN, DONE, FAULT. All are registered, and all outputs are registered.

Reset (rst_n=0, asynchronous, effective immediately regardless of clk):
- state=IDLE, prog_ctr=START_ADDR, cycle_cnt=0, running=0, done=0, fault=0.
- Reset asserted mid-RUN aborts with no further PC update.

IDLE:
- prog_ctr holds.
- start=1 → next cycle: RUN, prog_ctr=START_ADDR, cycle_cnt=0.

RUN, one update per clock:
- cycle_cnt increments by 1 every RUN cycle, including stall cycles. It saturates at 2**CW-1 (no wrap).
- Next-PC priority, highest first:
  1. halt=1 → DONE; prog_ctr holds (stays at the HALT address).
  2. stall=1 → prog_ctr holds; state stays RUN.
  3. abs_jump=1 → prog_ctr=target.
  4. rel_branch=1 and branch_taken=1 → prog_ctr = PC + sign-extended offset.
     - Computed in D+1 bits signed.
     - Result <0 or >2**D-1 → FAULT; prog_ctr holds.
  5. Otherwise → prog_ctr = PC+1.
     - If PC = 2**D-1, this is a wrap → FAULT; prog_ctr holds at 2**D-1.
- rel_branch=1 with branch_taken=0 behaves as case 5.
- Simultaneous abs_jump and rel_branch: abs_jump wins.
- Halt and stall together: halt wins.
- offset=0 with the branch taken re-executes the same address (legal; not a fault).
- start=1 while in RUN is ignored.

DONE / FAULT:
- Both are sticky; prog_ctr and cycle_cnt are frozen.
- done or fault is held high until start.
- start=1 → same restart as from IDLE; done/fault drop the cycle RUN is entered.

Latency:
- A redirect decided in cycle n appears on prog_ctr after the edge ending cycle n.
- No delay slot; the ROM is combinational, so the new instruction is visible in cycle n+1.

Exactly one of running/done/fault is high outside IDLE; all three are low in IDLE.

Test Plan (D=12, START_ADDR=0, OFFW=6, CW=16):
- Reset then start pulse, no redirects for 5 cycles → prog_ctr 0,1,2,3,4,5; running=1; cycle_cnt=5.
- At PC=10: abs_jump, target=0x200. Next cycle: rel_branch, taken, offset=-3 (6'b111101) → prog_ctr 0x200 then 0x1FD. Repeat with taken=0 → 0x201.
- At PC=20: stall for 3 cycles, then halt → prog_ctr stays 20 throughout; done=1; cycle_cnt counts the stall cycles; start → prog_ctr=0, done=0.
- Jump to 0xFFF, no redirect → fault=1, prog_ctr=0xFFF. At PC=2: taken offset=-5 → fault=1, prog_ctr=2.
- Same cycle: abs_jump (target=0x40), rel_branch taken, stall → PC holds. Next cycle: abs_jump+rel_branch → 0x40. Also: halt+stall together → DONE.
- rst_n low asynchronously mid-RUN at PC=0x33 (between edges) → prog_ctr=0 and running=0 immediately; no update until start.
